// File: rtl/axi_burst_master.sv
// rtl/axi_burst_master.sv - cache-line AXI4 master: one 8-beat INCR burst per refill or writeback
// Write wins over read in IDLE so a dirty line leaves before its replacement arrives.
module axi_burst_master #(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        arstn,
  input  logic                        i_start_read,
  input  logic                        i_start_write,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [BLOCK_WIDTH-1:0]      i_data_block,
  output logic [BLOCK_WIDTH-1:0]      o_data_block,
  output logic                        o_read_last,
  output logic                        o_b_resp,
  output logic                        o_error,
  output logic                        o_ar_valid,
  input  logic                        i_ar_ready,
  output logic [ADDR_WIDTH-1:0]       o_ar_addr,
  output logic [7:0]                  o_ar_len,
  output logic [2:0]                  o_ar_size,
  output logic [1:0]                  o_ar_burst,
  input  logic                        i_r_valid,
  output logic                        o_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   i_r_data,
  input  logic                        i_r_last,
  input  logic [1:0]                  i_r_resp,
  output logic                        o_aw_valid,
  input  logic                        i_aw_ready,
  output logic [ADDR_WIDTH-1:0]       o_aw_addr,
  output logic [7:0]                  o_aw_len,
  output logic [2:0]                  o_aw_size,
  output logic [1:0]                  o_aw_burst,
  output logic                        o_w_valid,
  input  logic                        i_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]   o_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] o_w_strb,
  output logic                        o_w_last,
  input  logic                        i_b_valid,
  output logic                        o_b_ready,
  input  logic [1:0]                  i_b_resp
);
  localparam int BEATS       = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t                 r_state;
  logic [BEAT_BITS-1:0]   r_beat;
  logic [BLOCK_WIDTH-1:0] r_wr_line;

  logic [BEAT_BITS-1:0]   w_next_beat;
  logic                   w_last_beat;
  logic [ADDR_WIDTH-1:0]  w_line_addr;
  logic                   w_unused_offset;

  assign w_next_beat     = r_beat + BEAT_BITS'(1);
  assign w_last_beat     = (r_beat == BEAT_BITS'(BEATS - 1));
  assign w_line_addr     = {i_addr[ADDR_WIDTH-1:OFFSET_BITS], OFFSET_BITS'(0)};
  assign w_unused_offset = ^i_addr[OFFSET_BITS-1:0];

  assign o_ar_len   = 8'(BEATS - 1);
  assign o_ar_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_ar_burst = 2'b01;
  assign o_aw_len   = 8'(BEATS - 1);
  assign o_aw_size  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_aw_burst = 2'b01;
  assign o_w_strb   = '1;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_wr_line    <= '0;
      o_data_block <= '0;
      o_read_last  <= 1'b0;
      o_b_resp     <= 1'b0;
      o_error      <= 1'b0;
      o_ar_valid   <= 1'b0;
      o_ar_addr    <= '0;
      o_r_ready    <= 1'b0;
      o_aw_valid   <= 1'b0;
      o_aw_addr    <= '0;
      o_w_valid    <= 1'b0;
      o_w_data     <= '0;
      o_w_last     <= 1'b0;
      o_b_ready    <= 1'b0;
    end else begin
      o_read_last <= 1'b0;
      o_b_resp    <= 1'b0;
      case (r_state)
        IDLE: begin
          // The requester still holds start during the completion pulse; ignore it then.
          if (!o_read_last && !o_b_resp) begin
            if (i_start_write) begin
              r_state    <= WR_ADDR;
              o_aw_valid <= 1'b1;
              o_aw_addr  <= w_line_addr;
              r_wr_line  <= i_data_block;
              r_beat     <= '0;
              o_error    <= 1'b0;
            end else if (i_start_read) begin
              r_state    <= RD_ADDR;
              o_ar_valid <= 1'b1;
              o_ar_addr  <= w_line_addr;
              r_beat     <= '0;
              o_error    <= 1'b0;
            end
          end
        end
        RD_ADDR: begin
          if (i_ar_ready) begin
            o_ar_valid <= 1'b0;
            o_r_ready  <= 1'b1;
            r_state    <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (i_r_valid) begin
            o_data_block[r_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_r_data;
            if ((i_r_resp != 2'b00) || (i_r_last != w_last_beat)) begin
              o_error <= 1'b1;
            end
            r_beat <= w_next_beat;
            // The beat count, not i_r_last, closes the burst.
            if (w_last_beat) begin
              o_r_ready   <= 1'b0;
              o_read_last <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        WR_ADDR: begin
          if (i_aw_ready) begin
            o_aw_valid <= 1'b0;
            o_w_valid  <= 1'b1;
            o_w_data   <= r_wr_line[0 +: AXI_DATA_WIDTH];
            o_w_last   <= 1'b0;
            r_state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (i_w_ready) begin
            r_beat <= w_next_beat;
            if (w_last_beat) begin
              o_w_valid <= 1'b0;
              o_w_last  <= 1'b0;
              o_b_ready <= 1'b1;
              r_state   <= WR_RESP;
            end else begin
              o_w_data <= r_wr_line[w_next_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
              o_w_last <= (w_next_beat == BEAT_BITS'(BEATS - 1));
            end
          end
        end
        WR_RESP: begin
          if (i_b_valid) begin
            o_b_ready <= 1'b0;
            o_b_resp  <= 1'b1;
            if (i_b_resp != 2'b00) begin
              o_error <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_master.sv
// tb/tb_axi_burst_master.sv - randomized bench for axi_burst_master with an in-bench AXI slave model
module tb_axi_burst_master;
  logic         clk = 1'b0;
  logic         arstn;
  logic         i_start_read, i_start_write;
  logic [63:0]  i_addr;
  logic [511:0] i_data_block;
  logic [511:0] o_data_block;
  logic         o_read_last, o_b_resp, o_error;
  logic         o_ar_valid, i_ar_ready;
  logic [63:0]  o_ar_addr;
  logic [7:0]   o_ar_len;
  logic [2:0]   o_ar_size;
  logic [1:0]   o_ar_burst;
  logic         i_r_valid, o_r_ready;
  logic [63:0]  i_r_data;
  logic         i_r_last;
  logic [1:0]   i_r_resp;
  logic         o_aw_valid, i_aw_ready;
  logic [63:0]  o_aw_addr;
  logic [7:0]   o_aw_len;
  logic [2:0]   o_aw_size;
  logic [1:0]   o_aw_burst;
  logic         o_w_valid, i_w_ready;
  logic [63:0]  o_w_data;
  logic [7:0]   o_w_strb;
  logic         o_w_last;
  logic         i_b_valid, o_b_ready;
  logic [1:0]   i_b_resp;

  int n_vec = 0;
  int n_err = 0;

  axi_burst_master dut (
    .clk(clk), .arstn(arstn),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_addr(i_addr), .i_data_block(i_data_block),
    .o_data_block(o_data_block), .o_read_last(o_read_last),
    .o_b_resp(o_b_resp), .o_error(o_error),
    .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr),
    .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst),
    .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data),
    .i_r_last(i_r_last), .i_r_resp(i_r_resp),
    .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr),
    .o_aw_len(o_aw_len), .o_aw_size(o_aw_size), .o_aw_burst(o_aw_burst),
    .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data),
    .o_w_strb(o_w_strb), .o_w_last(o_w_last),
    .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_slave();
    i_ar_ready = 1'b0; i_r_valid = 1'b0; i_r_data = '0; i_r_last = 1'b0; i_r_resp = 2'b00;
    i_aw_ready = 1'b0; i_w_ready = 1'b0; i_b_valid = 1'b0; i_b_resp = 2'b00;
  endtask

  task automatic check_fields();
    check("ar_len", o_ar_len, 8'd7);
    check("ar_size", o_ar_size, 3'b011);
    check("ar_burst", o_ar_burst, 2'b01);
    check("aw_len", o_aw_len, 8'd7);
    check("aw_size", o_aw_size, 3'b011);
    check("aw_burst", o_aw_burst, 2'b01);
    check("w_strb", o_w_strb, 8'hFF);
  endtask

  task automatic check_reset_state();
    check("rst_ar_valid", o_ar_valid, 0);
    check("rst_r_ready", o_r_ready, 0);
    check("rst_aw_valid", o_aw_valid, 0);
    check("rst_w_valid", o_w_valid, 0);
    check("rst_b_ready", o_b_ready, 0);
    check("rst_read_last", o_read_last, 0);
    check("rst_b_resp", o_b_resp, 0);
    check("rst_error", o_error, 0);
    check("rst_data_block", o_data_block, 0);
    check("rst_ar_addr", o_ar_addr, 0);
    check("rst_aw_addr", o_aw_addr, 0);
    check("rst_w_data", o_w_data, 0);
    check("rst_w_last", o_w_last, 0);
    check_fields();
  endtask

  // Slave model for one refill: the expected line is just the beats in arrival order.
  task automatic do_read(input logic [63:0] addr, input int ar_wait, input bit gaps,
                         input logic [7:0] resp_mask, input logic [7:0] last_mask,
                         input bit seq_data);
    logic [63:0]  bd [8];
    logic [511:0] exp_line;
    logic [63:0]  exp_addr;
    logic         exp_err;
    int beat, waits, c;
    bit done, ar_pend;
    for (int i = 0; i < 8; i++) begin
      bd[i] = seq_data ? 64'(i) : {$urandom, $urandom};
      exp_line[64*i +: 64] = bd[i];
    end
    exp_addr = addr & ~64'h3F;
    exp_err  = (resp_mask != 8'h00) || (last_mask != 8'h80);
    beat = 0; waits = ar_wait; c = 0; done = 1'b0; ar_pend = 1'b0;
    i_addr = addr;
    i_start_read = 1'b1;
    while (!done && c < 300) begin
      tick();
      c++;
      if (c == 1) begin
        check("rd_ar_first", o_ar_valid, 1);
        check("rd_aw_idle", o_aw_valid, 0);
        check("rd_err_clear", o_error, 0);
        check_fields();
      end
      if (ar_pend) check("ar_hold", o_ar_valid, 1);
      ar_pend = 1'b0;
      quiet_slave();
      if (o_read_last) begin
        done = 1'b1;
      end else begin
        if (o_ar_valid) begin
          check("ar_addr", o_ar_addr, exp_addr);
          if (waits > 0) begin
            waits--;
            ar_pend = 1'b1;
          end else begin
            i_ar_ready = 1'b1;
          end
        end
        if (o_r_ready && beat < 8 && (!gaps || $urandom_range(0, 1) == 1)) begin
          i_r_valid = 1'b1;
          i_r_data  = bd[beat];
          i_r_resp  = resp_mask[beat] ? 2'b10 : 2'b00;
          i_r_last  = last_mask[beat];
          beat++;
        end
      end
    end
    check("rd_done", done, 1);
    check("rd_beats", beat, 8);
    check("rd_line", o_data_block, exp_line);
    check("rd_error", o_error, exp_err);
    if (ar_wait == 0 && !gaps) check("rd_latency", c, 10);
    tick();
    check("rd_pulse_width", o_read_last, 0);
    check("rd_no_retrigger", o_ar_valid, 0);
    i_start_read = 1'b0;
  endtask

  // wmode: 0 always ready, 1 ready every other cycle, 2 random ready.
  task automatic do_write(input logic [511:0] line, input logic [63:0] addr, input int aw_wait,
                          input int wmode, input int b_delay, input logic [1:0] bresp,
                          input bit also_read, input int rst_beat);
    logic [63:0] exp_addr;
    int wb, waits, bcnt, c;
    bit done, rst_hit, aw_done, aw_pend, tog, rdy;
    exp_addr = addr & ~64'h3F;
    wb = 0; waits = aw_wait; bcnt = b_delay; c = 0;
    done = 1'b0; rst_hit = 1'b0; aw_done = 1'b0; aw_pend = 1'b0; tog = 1'b0;
    i_addr = addr;
    i_data_block = line;
    i_start_write = 1'b1;
    if (also_read) i_start_read = 1'b1;
    while (!done && !rst_hit && c < 300) begin
      tick();
      c++;
      if (c == 1) begin
        check("wr_aw_first", o_aw_valid, 1);
        check("wr_ar_idle", o_ar_valid, 0);
        check("wr_err_clear", o_error, 0);
      end
      if (aw_pend) check("aw_hold", o_aw_valid, 1);
      aw_pend = 1'b0;
      quiet_slave();
      if (o_b_resp) begin
        done = 1'b1;
      end else begin
        if (o_w_valid) begin
          check("w_after_aw", aw_done, 1);
          check("w_data", o_w_data, (wb < 8) ? line[64*(wb%8) +: 64] : 64'hX);
          check("w_last", o_w_last, wb == 7);
          if (wb == rst_beat) begin
            rst_hit = 1'b1;
          end else begin
            case (wmode)
              0:       rdy = 1'b1;
              1:       rdy = tog;
              default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            tog = !tog;
            i_w_ready = rdy;
            if (rdy) wb++;
          end
        end
        if (o_aw_valid) begin
          check("aw_addr", o_aw_addr, exp_addr);
          if (waits > 0) begin
            waits--;
            aw_pend = 1'b1;
          end else begin
            i_aw_ready = 1'b1;
            aw_done = 1'b1;
          end
        end
        if (o_b_ready) begin
          check("b_after_w", wb, 8);
          if (bcnt > 0) begin
            bcnt--;
          end else begin
            i_b_valid = 1'b1;
            i_b_resp  = bresp;
          end
        end
      end
    end
    if (rst_hit) begin
      arstn = 1'b0;
      tick();
      check_reset_state();
      arstn = 1'b1;
      i_start_write = 1'b0;
      i_start_read = 1'b0;
      quiet_slave();
      tick();
      check("rst_stays_idle", o_aw_valid, 0);
    end else begin
      check("wr_done", done, 1);
      check("wr_beats", wb, 8);
      check("wr_error", o_error, bresp != 2'b00);
      if (aw_wait == 0 && wmode == 0 && b_delay == 0) check("wr_latency", c, 11);
      tick();
      check("wr_pulse_width", o_b_resp, 0);
      check("wr_no_retrigger_aw", o_aw_valid, 0);
      check("wr_no_early_ar", o_ar_valid, 0);
      i_start_write = 1'b0;
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] f_line;
    logic [63:0]  a;
    logic [7:0]   rm, lm;
    arstn = 1'b0;
    i_start_read = 1'b0;
    i_start_write = 1'b0;
    i_addr = '0;
    i_data_block = '0;
    quiet_slave();
    repeat (3) tick();
    check_reset_state();
    arstn = 1'b1;
    tick();

    do_read(64'h1234_5678_9ABC_DEF7, 0, 1'b0, 8'h00, 8'h80, 1'b1);
    check("rd_seq_line", o_data_block, {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0});

    for (int i = 0; i < 8; i++) f_line[64*i +: 64] = 64'hF0 + 64'(i);
    do_write(f_line, 64'hCAFE_0000_0000_1042, 0, 1, 0, 2'b00, 1'b0, -1);
    do_write(rand_line(), 64'h0000_0000_0000_0000, 0, 0, 0, 2'b00, 1'b0, -1);

    do_write(rand_line(), {$urandom, $urandom}, 0, 0, 0, 2'b00, 1'b1, -1);
    do_read({$urandom, $urandom}, 0, 1'b0, 8'h00, 8'h80, 1'b0);

    do_read({$urandom, $urandom}, 0, 1'b0, 8'h08, 8'h80, 1'b0);
    do_read({$urandom, $urandom}, 5, 1'b0, 8'h00, 8'hA0, 1'b0);
    do_read({$urandom, $urandom}, 0, 1'b1, 8'h00, 8'h00, 1'b0);
    do_write(rand_line(), {$urandom, $urandom}, 2, 2, 3, 2'b10, 1'b0, -1);

    do_write(rand_line(), {$urandom, $urandom}, 0, 0, 0, 2'b00, 1'b0, 4);
    do_read(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 8'h00, 8'h80, 1'b0);

    for (int n = 0; n < 24; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        rm = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        lm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h80;
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 1) == 1, rm, lm, 1'b0);
      end else begin
        do_write(rand_line(), a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, 1'b0, -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
